// File: rtl/distance_filter_pkg.sv
// Shared constants and state encodings for the distance filter and the
// ranging stage that feeds it.
package distance_filter_pkg;

  localparam int unsigned W_DEF           = 12;
  localparam int unsigned AVG_LOG2_DEF    = 2;
  localparam int unsigned MAX_CM_DEF      = 400;
  localparam int unsigned NEAR_CM_DEF     = 20;
  localparam int unsigned FAR_CM_DEF      = 30;
  localparam int unsigned HOLD_DEF        = 3;
  // One 60 ms measurement period at 50 MHz.
  localparam int unsigned PERIOD_CYC      = 3_000_000;
  // Two silent measurement periods mean the sensor is gone.
  localparam int unsigned TIMEOUT_CYC_DEF = 2 * PERIOD_CYC;

  typedef enum logic {
    AVG_FILL = 1'b0,
    AVG_RUN  = 1'b1
  } avg_state_t;

  typedef enum logic {
    PRES_FAR  = 1'b0,
    PRES_NEAR = 1'b1
  } pres_state_t;

endpackage

// File: rtl/moving_avg.sv
// 2^AVG_LOG2-deep moving average over accepted samples.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   flush          - drop all history and return to FILL
//   din, din_valid - qualified sample and its strobe
//   avg, avg_valid - truncated average, pulsed once per sample once full
module moving_avg
  import distance_filter_pkg::*;
#(
  parameter int unsigned W        = W_DEF,
  parameter int unsigned AVG_LOG2 = AVG_LOG2_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic [W-1:0] avg,
  output logic         avg_valid
);

  localparam int unsigned N  = 1 << AVG_LOG2;
  localparam int unsigned SW = W + AVG_LOG2;
  localparam int unsigned CW = AVG_LOG2 + 1;

  avg_state_t          state;
  logic [W-1:0]        ring [N];
  logic [AVG_LOG2-1:0] ptr;
  logic [CW-1:0]       fill_cnt;
  logic [SW-1:0]       sum;
  logic [SW-1:0]       oldest_c;
  logic [SW-1:0]       sum_next_c;

  // In FILL the slot under ptr holds stale data, so nothing is subtracted.
  always_comb begin
    oldest_c = '0;
    if (state == AVG_RUN) oldest_c = SW'(ring[ptr]);
    sum_next_c = sum + SW'(din) - oldest_c;
  end

  always_ff @(posedge clk) begin
    avg_valid <= 1'b0;
    if (reset) begin
      state    <= AVG_FILL;
      ptr      <= '0;
      fill_cnt <= '0;
      sum      <= '0;
      avg      <= '0;
      for (int i = 0; i < int'(N); i++) ring[i] <= '0;
    end else if (flush) begin
      state    <= AVG_FILL;
      ptr      <= '0;
      fill_cnt <= '0;
      sum      <= '0;
      avg      <= '0;
    end else if (din_valid) begin
      ring[ptr] <= din;
      ptr       <= ptr + AVG_LOG2'(1);
      sum       <= sum_next_c;
      case (state)
        AVG_FILL: begin
          fill_cnt <= fill_cnt + CW'(1);
          if (fill_cnt == CW'(N - 1)) begin
            state     <= AVG_RUN;
            avg       <= W'(sum_next_c >> AVG_LOG2);
            avg_valid <= 1'b1;
          end
        end
        AVG_RUN: begin
          avg       <= W'(sum_next_c >> AVG_LOG2);
          avg_valid <= 1'b1;
        end
        default: state <= AVG_FILL;
      endcase
    end
  end

endmodule

// File: rtl/distance_filter.sv
// Range-checks raw ultrasonic samples, averages them, and derives a
// debounced hysteretic presence flag plus a sensor-silence fault.
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   cm_in, cm_valid    - raw distance and its one-cycle strobe
//   dist_avg,avg_valid - filtered distance and its update pulse
//   near, near_evt     - presence level and FAR->NEAR pulse
//   sensor_fault       - no strobe seen for TIMEOUT_CYC cycles
module distance_filter
  import distance_filter_pkg::*;
#(
  parameter int unsigned W           = W_DEF,
  parameter int unsigned AVG_LOG2    = AVG_LOG2_DEF,
  parameter int unsigned MAX_CM      = MAX_CM_DEF,
  parameter int unsigned NEAR_CM     = NEAR_CM_DEF,
  parameter int unsigned FAR_CM      = FAR_CM_DEF,
  parameter int unsigned HOLD        = HOLD_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] cm_in,
  input  logic         cm_valid,
  output logic [W-1:0] dist_avg,
  output logic         avg_valid,
  output logic         near,
  output logic         near_evt,
  output logic         sensor_fault
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned HW = $clog2(HOLD + 1);

  pres_state_t   pstate;
  logic [TW-1:0] tcnt;
  logic [HW-1:0] hcnt;
  logic [HW-1:0] hcnt_inc_c;
  logic          accept_c;
  logic          timeout_c;
  logic          qualify_c;

  assign accept_c  = cm_valid && (cm_in != '0) && (cm_in <= W'(MAX_CM));
  // Any strobe, even a rejected one, beats the timeout in the same cycle.
  assign timeout_c = !cm_valid && (tcnt == TW'(TIMEOUT_CYC));

  moving_avg #(
    .W        (W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk       (clk),
    .reset     (reset),
    .flush     (timeout_c),
    .din       (cm_in),
    .din_valid (accept_c),
    .avg       (dist_avg),
    .avg_valid (avg_valid)
  );

  // Silence counter: restarts on every strobe, saturates at the limit.
  always_ff @(posedge clk) begin
    if (reset || cm_valid) begin
      tcnt <= '0;
    end else if (tcnt != TW'(TIMEOUT_CYC)) begin
      tcnt <= tcnt + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sensor_fault <= 1'b0;
    end else if (timeout_c) begin
      sensor_fault <= 1'b1;
    end else if (accept_c) begin
      sensor_fault <= 1'b0;
    end
  end

  // Threshold that counts toward leaving the current presence state.
  always_comb begin
    qualify_c  = (pstate == PRES_NEAR) ? (dist_avg >= W'(FAR_CM))
                                       : (dist_avg <= W'(NEAR_CM));
    hcnt_inc_c = hcnt + HW'(1);
  end

  // Presence FSM, stepped once per fresh average.
  always_ff @(posedge clk) begin
    near_evt <= 1'b0;
    if (reset || timeout_c) begin
      pstate <= PRES_FAR;
      hcnt   <= '0;
      near   <= 1'b0;
    end else if (avg_valid) begin
      if (!qualify_c) begin
        hcnt <= '0;
      end else if (hcnt_inc_c == HW'(HOLD)) begin
        hcnt <= '0;
        case (pstate)
          PRES_FAR: begin
            pstate   <= PRES_NEAR;
            near     <= 1'b1;
            near_evt <= 1'b1;
          end
          PRES_NEAR: begin
            pstate <= PRES_FAR;
            near   <= 1'b0;
          end
          default: pstate <= PRES_FAR;
        endcase
      end else begin
        hcnt <= hcnt_inc_c;
      end
    end
  end

endmodule

// File: tb/tb_distance_filter.sv
// Bench for distance_filter: directed table plus randomized traffic checked
// every cycle against a queue-based model of the filter's rules.
module tb_distance_filter;

  localparam int unsigned W       = 12;
  localparam int unsigned TO      = 50;
  localparam int          MAXV    = 400;
  localparam int          NEARV   = 20;
  localparam int          FARV    = 30;
  localparam int          HOLDV   = 3;
  localparam int          DEPTH   = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] cm_in;
  logic         cm_valid;
  logic [W-1:0] dist_avg;
  logic         avg_valid;
  logic         near;
  logic         near_evt;
  logic         sensor_fault;

  int n_tests = 0;
  int n_fail  = 0;

  distance_filter #(
    .W           (W),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cm_in        (cm_in),
    .cm_valid     (cm_valid),
    .dist_avg     (dist_avg),
    .avg_valid    (avg_valid),
    .near         (near),
    .near_evt     (near_evt),
    .sensor_fault (sensor_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic         s_rst = 1'b1;
  logic         s_v   = 1'b0;
  logic [W-1:0] s_cm  = '0;
  bit           started = 1'b0;

  int win[$];
  int m_idle = 0, m_h = 0;
  int e_av = 0, e_avg = 0, e_near = 0, e_evt = 0, e_fault = 0;
  bit avg_known = 1'b1;

  always @(posedge clk) begin
    s_rst   <= reset;
    s_v     <= cm_valid;
    s_cm    <= cm_in;
    started <= 1'b1;
  end

  task automatic model_step(input bit rst, input bit v, input int cm);
    bit acc, tmo, qual;
    int sum;
    if (rst) begin
      win.delete();
      m_idle = 0; m_h = 0;
      e_av = 0; e_avg = 0; e_near = 0; e_evt = 0; e_fault = 0;
      avg_known = 1'b1;
      return;
    end
    acc = v && cm >= 1 && cm <= MAXV;
    tmo = !v && m_idle == TO;
    e_evt = 0;
    if (tmo) begin
      e_fault = 1; e_near = 0; m_h = 0; e_av = 0;
      win.delete();
      avg_known = 1'b0;
    end else begin
      if (e_av == 1) begin
        qual = (e_near == 1) ? (e_avg >= FARV) : (e_avg <= NEARV);
        m_h = qual ? m_h + 1 : 0;
        if (m_h == HOLDV) begin
          m_h = 0;
          e_near = 1 - e_near;
          e_evt = e_near;
        end
      end
      e_av = 0;
      if (acc) begin
        e_fault = 0;
        win.push_back(cm);
        if (win.size() > DEPTH) void'(win.pop_front());
        if (win.size() == DEPTH) begin
          sum = 0;
          foreach (win[i]) sum += win[i];
          e_av = 1; e_avg = sum / DEPTH; avg_known = 1'b1;
        end
      end
    end
    if (v) m_idle = 0;
    else if (m_idle < TO) m_idle++;
  endtask

  always @(negedge clk) begin
    if (started) begin
      model_step(s_rst, s_v, int'(s_cm));
      chk("model avg_valid", avg_valid, e_av);
      if (avg_known) chk("model dist_avg", dist_avg, e_avg);
      chk("model near", near, e_near);
      chk("model near_evt", near_evt, e_evt);
      chk("model sensor_fault", sensor_fault, e_fault);
    end
  end

  // ---------------- directed helpers ----------------
  typedef struct {
    bit rst;
    int cm;
    int av;
    int avg;
    int nr;
    int evt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit rst, input int cm, input int av, input int avg,
                     input int nr, input int evt);
    vec_t e;
    e.rst = rst; e.cm = cm; e.av = av; e.avg = avg; e.nr = nr; e.evt = evt;
    tbl.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cm_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset dist_avg", dist_avg, 0);
    chk("reset avg_valid", avg_valid, 0);
    chk("reset near", near, 0);
    chk("reset near_evt", near_evt, 0);
    chk("reset sensor_fault", sensor_fault, 0);
  endtask

  // Strobe one sample; avg checked one cycle later, presence two later.
  // A negative expected average means the value is not checked.
  task automatic send(input int cm, input int av, input int avg,
                      input int nr, input int evt);
    cm_in = W'(cm);
    cm_valid = 1'b1;
    @(negedge clk);
    cm_valid = 1'b0;
    cm_in = W'($urandom);
    chk("avg_valid", avg_valid, av);
    if (avg >= 0) chk("dist_avg", dist_avg, avg);
    @(negedge clk);
    chk("near", near, nr);
    chk("near_evt", near_evt, evt);
    chk("avg_valid width", avg_valid, 0);
    @(negedge clk);
    chk("near_evt width", near_evt, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    cm_valid = 1'b0;
    cm_in = '0;

    // fill, then steady
    add(1, 100, 0, 0, 0, 0);  add(0, 100, 0, 0, 0, 0);
    add(0, 100, 0, 0, 0, 0);  add(0, 100, 1, 100, 0, 0);
    add(0, 50, 1, 87, 0, 0);  add(0, 50, 1, 75, 0, 0);
    add(0, 50, 1, 62, 0, 0);  add(0, 50, 1, 50, 0, 0);
    // rejects leave the average alone
    add(0, 0, 0, 50, 0, 0);   add(0, 500, 0, 50, 0, 0);
    add(0, 401, 0, 50, 0, 0);
    // walk down to NEAR
    add(0, 15, 1, 41, 0, 0);  add(0, 15, 1, 32, 0, 0);
    add(0, 15, 1, 23, 0, 0);  add(0, 15, 1, 15, 0, 0);
    add(0, 15, 1, 15, 0, 0);  add(0, 15, 1, 15, 1, 1);
    add(0, 15, 1, 15, 1, 0);
    // inside the hysteresis band NEAR holds
    add(0, 25, 1, 17, 1, 0);  add(0, 25, 1, 20, 1, 0);
    add(0, 25, 1, 22, 1, 0);  add(0, 25, 1, 25, 1, 0);
    // back to FAR without an event
    add(0, 40, 1, 28, 1, 0);  add(0, 40, 1, 32, 1, 0);
    add(0, 40, 1, 36, 1, 0);  add(0, 40, 1, 40, 0, 0);
    // debounce broken by an in-band average, then re-qualified
    add(1, 20, 0, 0, 0, 0);   add(0, 20, 0, 0, 0, 0);
    add(0, 20, 0, 0, 0, 0);   add(0, 20, 1, 20, 0, 0);
    add(0, 20, 1, 20, 0, 0);  add(0, 28, 1, 22, 0, 0);
    add(0, 12, 1, 20, 0, 0);  add(0, 12, 1, 18, 0, 0);
    add(0, 12, 1, 16, 1, 1);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      send(tbl[i].cm, tbl[i].av, tbl[i].avg, tbl[i].nr, tbl[i].evt);
    end

    // timeout while NEAR
    repeat (TO - 2) @(negedge clk);
    chk("fault before limit", sensor_fault, 0);
    chk("near before limit", near, 1);
    @(negedge clk);
    chk("fault at limit", sensor_fault, 1);
    chk("near forced low", near, 0);
    chk("no event on timeout", near_evt, 0);
    send(20, 0, -1, 0, 0);
    chk("fault cleared", sensor_fault, 0);
    send(20, 0, -1, 0, 0);
    send(20, 0, -1, 0, 0);
    send(20, 1, 20, 0, 0);

    // rejected strobe on the exact timeout cycle wins and restarts the count
    repeat (TO - 2) @(negedge clk);
    cm_in = '0;
    cm_valid = 1'b1;
    @(negedge clk);
    cm_valid = 1'b0;
    chk("collision no fault", sensor_fault, 0);
    repeat (TO) @(negedge clk);
    chk("collision restart pre", sensor_fault, 0);
    @(negedge clk);
    chk("collision restart fault", sensor_fault, 1);

    // reset in the middle of FILL, then range boundaries
    send(1, 0, -1, 0, 0);
    chk("fault cleared again", sensor_fault, 0);
    send(400, 0, -1, 0, 0);
    do_reset();
    send(30, 0, 0, 0, 0);
    send(30, 0, 0, 0, 0);
    send(30, 0, 0, 0, 0);
    send(30, 1, 30, 0, 0);
    send(400, 1, 122, 0, 0);
    send(1, 1, 115, 0, 0);
    send(401, 0, 115, 0, 0);

    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 1500; i++) begin
      int r, v, r2;
      r = $urandom_range(0, 19);
      if (r == 0) v = 0;
      else if (r == 1) v = $urandom_range(401, 4095);
      else if (r == 2) v = ($urandom_range(0, 1) == 1) ? 1 : 400;
      else if (r < 14) v = $urandom_range(5, 45);
      else v = $urandom_range(1, 400);
      cm_in = W'(v);
      cm_valid = 1'b1;
      @(negedge clk);
      cm_valid = 1'b0;
      cm_in = W'($urandom);
      r2 = $urandom_range(0, 99);
      if (r2 < 2) begin
        repeat (TO - 2 + $urandom_range(0, 6)) @(negedge clk);
      end else if (r2 == 2) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end else begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/distance_filter.md
# distance_filter

Downstream consumer of the ultrasonic ranging stage. Takes each raw centimetre measurement and its strobe, rejects out-of-range samples, and keeps a 4-sample moving average. From that average it derives a debounced, hysteretic "object near" flag plus a one-cycle event pulse, and watches for a silent or broken sensor with a timeout. Its outputs drive the application logic that reacts to presence.

## Interface
Parameters:
- `W`, 12: measurement width in cm, matching the ranging stage output.
- `AVG_LOG2`, 2: log2 of the averaging depth (4 samples).
- `MAX_CM`, 400: largest valid sample; `0` and values above this are rejected.
- `NEAR_CM`, 20: average at or below this counts toward NEAR.
- `FAR_CM`, 30: average at or above this counts toward FAR. Must satisfy `NEAR_CM < FAR_CM`.
- `HOLD`, 3: consecutive qualifying averages required to change presence state.
- `TIMEOUT_CYC`, 6_000_000: cycles without `cm_valid` before fault is declared (two 60 ms measurement periods at 50 MHz).

Ports:
- `clk`, in, 1: 50 MHz system clock.
- `reset`, in, 1: synchronous, active-high reset.
- `cm_in`, in, W: raw distance in cm. Sampled only when `cm_valid` is high.
- `cm_valid`, in, 1: one-cycle strobe marking a completed measurement.
- `dist_avg`, out, W: filtered distance.
- `avg_valid`, out, 1: one-cycle pulse when `dist_avg` updates.
- `near`, out, 1: presence level.
- `near_evt`, out, 1: one-cycle pulse on the FAR→NEAR transition.
- `sensor_fault`, out, 1: timeout fault level.

## Operation
- **Reset state.** All outputs are 0. The buffer, running sum, fill count, hysteresis counter and timeout counter are cleared. The averager is in FILL and the presence FSM is in FAR.
- **Sample qualification.** A sample is accepted when `cm_valid` is high and `1 <= cm_in <= MAX_CM`. A rejected sample leaves the buffer, sum and outputs unchanged, but it still restarts the timeout counter.
- **Averager FSM.**
  - FILL: each accepted sample is written at the write pointer, and sum, pointer and fill count are updated. The Nth accepted sample (N = 2^AVG_LOG2) moves the FSM to RUN and produces the first `avg_valid`. No `avg_valid` is produced while in FILL.
  - RUN: each accepted sample overwrites the oldest entry. The sum is updated as `sum + new − old`. `avg_valid` pulses.
- **Arithmetic.**
  - The sum register is W+AVG_LOG2 bits wide and cannot overflow.
  - `dist_avg = sum >> AVG_LOG2`, truncated.
  - The pointer wraps modulo N.
- **Presence FSM.** Evaluated once per `avg_valid`, using the new `dist_avg`.
  - FAR: if `dist_avg <= NEAR_CM`, increment `hcnt`; otherwise set `hcnt = 0`. When `hcnt` reaches HOLD, go to NEAR, set `hcnt = 0`, set `near = 1`, and pulse `near_evt`.
  - NEAR: if `dist_avg >= FAR_CM`, increment `hcnt`; otherwise set `hcnt = 0`. When `hcnt` reaches HOLD, go to FAR, set `hcnt = 0`, and set `near = 0`.
  - An average strictly between `NEAR_CM` and `FAR_CM` clears `hcnt` in either state.
- **Timeout.**
  - The counter increments every cycle and restarts on any `cm_valid`.
  - When it reaches TIMEOUT_CYC: set `sensor_fault = 1`, force the presence FSM to FAR with `near = 0` and no event, and flush the averager back to FILL (sum, count and pointer cleared). The counter then holds.
  - The fault clears on the next accepted sample, which becomes the first FILL entry.
- **Simultaneous events.**
  - `cm_valid` in the same cycle the counter hits TIMEOUT_CYC: `cm_valid` wins, and no fault is raised.
  - `reset` overrides everything.

## Timing
- Cycle T (`cm_valid`, accepted): buffer, sum and pointer update at the T edge.
- T+1: `dist_avg` valid and `avg_valid` high for exactly one cycle.
- T+2: `near` and `near_evt` reflect that average. `near_evt` is high for exactly one cycle.
- `sensor_fault` rises one cycle after the counter reaches TIMEOUT_CYC.
- Back-to-back `cm_valid` on consecutive cycles must be accepted without loss; throughput is 1 sample/cycle.

## Structure
- **Shared package.** Default `W`, the `MAX_CM`, `NEAR_CM` and `FAR_CM` constants, the `TIMEOUT_CYC` default, and the averager and presence state encodings. The ranging stage reuses `W` and the period constant from this package.
- **Sub-module `moving_avg`.** Contains the ring buffer, running sum and FILL/RUN FSM. Inputs are `clk`, `reset`, `flush`, `din` and `din_valid`; outputs are `avg` and `avg_valid`.
- **Top level.** Qualification, the presence FSM and the timeout counter stay in the top level.

## Test plan
- **Fill then steady.** Send 100, 100, 100, 100 → first `avg_valid` follows the 4th sample, with `dist_avg = 100`; no `avg_valid` after samples 1–3.
- **Reject.** With the buffer holding 4×50 in RUN, send `cm_in = 0` and then `cm_in = 500` → no `avg_valid`, `dist_avg` stays 50, and the timeout counter restarts on each strobe.
- **Hysteresis.**
  - From FAR with the buffer at 4×15, send 15 three times → `near` rises after the 3rd average and `near_evt` pulses exactly once.
  - Then send 25 repeatedly → `near` stays 1.
  - Then send 40 until the average reaches ≥30 for 3 consecutive averages → `near` falls, with no `near_evt`.
- **Debounce break.** In FAR, send averages 15, 15, 25, 15, 15 → `near` stays 0, because `hcnt` is cleared by 25.
- **Timeout.** While in NEAR, stop strobes for TIMEOUT_CYC cycles → `sensor_fault = 1` and `near = 0`. The next valid sample clears the fault, and `avg_valid` returns only after 4 further accepted samples.
- **Collision and reset.** Pulse `cm_valid` exactly on the timeout cycle → no fault. Assert `reset` mid-FILL → all outputs 0, and 4 new samples are needed before `avg_valid`.
